// File: rtl/pwm_capture.sv
// Serial capture receiver for PWM-shaped waveforms: reassembles LSB-first words
// sampled once per programmable bit period and measures recent high/low pulse widths.
module pwm_capture #(
    parameter int SYNC_STAGES = 2,
    parameter int WORD_W      = 32
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              cap_en,
    input  logic              cap_rst,
    input  logic [31:0]       cap_cfg,
    input  logic              pwm_in,
    input  logic              rx_ack,
    output logic [WORD_W-1:0] rx_word,
    output logic              rx_valid,
    output logic              rx_irq,
    output logic              rx_overrun,
    output logic              busy,
    output logic [15:0]       hi_width,
    output logic [15:0]       lo_width
);

    localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_W - 1);
    localparam logic [15:0] RUN_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_prev_q, s_prev_d;
    logic [15:0]            phase_q, phase_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [WORD_W-1:0]      shift_q, shift_d;
    logic [WORD_W-1:0]      rx_word_q, rx_word_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_irq_q, rx_irq_d;
    logic                   rx_overrun_q, rx_overrun_d;
    logic [15:0]            run_len_q, run_len_d;
    logic [15:0]            hi_width_q, hi_width_d;
    logic [15:0]            lo_width_q, lo_width_d;

    logic                   s_in;
    logic                   rise;
    logic [15:0]            per;
    logic [15:0]            samp_phase;
    logic [15:0]            cur_phase;
    logic                   active;
    logic                   word_done;
    logic [WORD_W-1:0]      shifted;

    // Input synchronizer and edge detect
    always_comb begin
        sync_d   = {sync_q[SYNC_STAGES-2:0], pwm_in};
        s_in     = sync_q[SYNC_STAGES-1];
        s_prev_d = s_in;
        rise     = s_in & ~s_prev_q;
    end

    // Sample phase is clamped to the last phase of the bit, so P=0 samples every cycle
    always_comb begin
        per        = cap_cfg[15:0];
        samp_phase = (cap_cfg[31:16] > per) ? per : cap_cfg[31:16];
        shifted    = {s_in, shift_q[WORD_W-1:1]};
    end

    // Capture FSM and bit counters
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        cur_phase = phase_q;
        active    = 1'b0;
        word_done = 1'b0;

        if (!cap_en) begin
            state_d   = ST_IDLE;
            phase_d   = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    phase_d   = '0;
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = ST_ARM;
                end
                ST_ARM: begin
                    // The rise cycle itself is phase 0 of bit 0.
                    if (rise) begin
                        state_d   = ST_RUN;
                        cur_phase = '0;
                        active    = 1'b1;
                    end
                end
                ST_RUN: begin
                    active = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (active) begin
                phase_d = (cur_phase == per) ? 16'd0 : cur_phase + 16'd1;
                if (cur_phase == samp_phase) begin
                    shift_d = shifted;
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        word_done = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
        end

        if (cap_rst) begin
            state_d   = ST_IDLE;
            phase_d   = '0;
            bit_cnt_d = '0;
            shift_d   = '0;
        end
    end

    // Receive holding register, valid/overrun flags and interrupt pulse
    always_comb begin
        rx_word_d    = rx_word_q;
        rx_valid_d   = rx_valid_q;
        rx_overrun_d = rx_overrun_q;
        rx_irq_d     = 1'b0;

        if (word_done) begin
            rx_word_d  = shifted;
            rx_valid_d = 1'b1;
            rx_irq_d   = 1'b1;
            if (rx_valid_q && !rx_ack) begin
                rx_overrun_d = 1'b1;
            end
        end else if (rx_ack) begin
            rx_valid_d = 1'b0;
        end

        if (cap_rst) begin
            rx_word_d    = '0;
            rx_valid_d   = 1'b0;
            rx_overrun_d = 1'b0;
            rx_irq_d     = 1'b0;
        end
    end

    // Pulse width meter, runs whenever capture is enabled
    always_comb begin
        run_len_d  = run_len_q;
        hi_width_d = hi_width_q;
        lo_width_d = lo_width_q;

        if (cap_rst) begin
            run_len_d  = '0;
            hi_width_d = '0;
            lo_width_d = '0;
        end else if (!cap_en) begin
            run_len_d = '0;
        end else if (s_in != s_prev_q) begin
            if (s_prev_q) begin
                hi_width_d = run_len_q;
            end else begin
                lo_width_d = run_len_q;
            end
            run_len_d = 16'd1;
        end else if (run_len_q != RUN_MAX) begin
            run_len_d = run_len_q + 16'd1;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q      <= ST_IDLE;
            sync_q       <= '0;
            s_prev_q     <= 1'b0;
            phase_q      <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            rx_word_q    <= '0;
            rx_valid_q   <= 1'b0;
            rx_irq_q     <= 1'b0;
            rx_overrun_q <= 1'b0;
            run_len_q    <= '0;
            hi_width_q   <= '0;
            lo_width_q   <= '0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            s_prev_q     <= s_prev_d;
            phase_q      <= phase_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            rx_word_q    <= rx_word_d;
            rx_valid_q   <= rx_valid_d;
            rx_irq_q     <= rx_irq_d;
            rx_overrun_q <= rx_overrun_d;
            run_len_q    <= run_len_d;
            hi_width_q   <= hi_width_d;
            lo_width_q   <= lo_width_d;
        end
    end

    assign rx_word    = rx_word_q;
    assign rx_valid   = rx_valid_q;
    assign rx_irq     = rx_irq_q;
    assign rx_overrun = rx_overrun_q;
    assign busy       = (state_q == ST_RUN);
    assign hi_width   = hi_width_q;
    assign lo_width   = lo_width_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expected words are queued as frames are driven
// and compared whenever the receiver raises its interrupt.
`timescale 1ns/1ps
module tb_pwm_capture;

    logic        hclk;
    logic        hresetn;
    logic        cap_en;
    logic        cap_rst;
    logic [31:0] cap_cfg;
    logic        pwm_in;
    logic        rx_ack;
    logic [31:0] rx_word;
    logic        rx_valid;
    logic        rx_irq;
    logic        rx_overrun;
    logic        busy;
    logic [15:0] hi_width;
    logic [15:0] lo_width;

    int          n_chk  = 0;
    int          n_pass = 0;
    int          irq_cnt = 0;
    int          irq0;
    bit          sb_ignore;
    logic [31:0] sb_q[$];
    logic [31:0] exp_w;

    pwm_capture #(.SYNC_STAGES(2), .WORD_W(32)) dut (
        .hclk       (hclk),
        .hresetn    (hresetn),
        .cap_en     (cap_en),
        .cap_rst    (cap_rst),
        .cap_cfg    (cap_cfg),
        .pwm_in     (pwm_in),
        .rx_ack     (rx_ack),
        .rx_word    (rx_word),
        .rx_valid   (rx_valid),
        .rx_irq     (rx_irq),
        .rx_overrun (rx_overrun),
        .busy       (busy),
        .hi_width   (hi_width),
        .lo_width   (lo_width)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    // Drives one bit per bp cycles at negedges; with decoy, every cycle of bits
    // n>0 except the sample offset carries the inverted value.
    task automatic drive_bits(input logic [63:0] bits, input int nbits, input int bp,
                              input int s_eff, input bit decoy, input int ack_cyc);
        int   n;
        int   off;
        logic b;
        for (int c = 0; c < nbits * bp; c++) begin
            @(negedge hclk);
            n   = c / bp;
            off = c % bp;
            b   = bits[n[5:0]];
            if (decoy && n > 0 && off != s_eff) b = ~b;
            pwm_in = b;
            rx_ack = (c == ack_cyc);
        end
        @(negedge hclk);
        rx_ack = 1'b0;
    endtask

    task automatic rearm();
        @(negedge hclk);
        cap_en = 1'b0;
        pwm_in = 1'b0;
        repeat (4) @(negedge hclk);
        cap_en = 1'b1;
        repeat (3) @(negedge hclk);
    endtask

    task automatic pulse_rst();
        @(negedge hclk);
        cap_rst = 1'b1;
        @(negedge hclk);
        cap_rst = 1'b0;
    endtask

    always @(negedge hclk) begin
        if (rx_irq === 1'b1) begin
            irq_cnt++;
            if (!sb_ignore) begin
                if (sb_q.size() == 0) begin
                    check("irq_unexpected", 32'(rx_irq), 32'd0);
                end else begin
                    exp_w = sb_q.pop_front();
                    check("rx_word", rx_word, exp_w);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, n_chk=%0d", n_chk);
        $fatal(1, "timeout");
    end

    initial begin
        hresetn   = 1'b0;
        cap_en    = 1'b0;
        cap_rst   = 1'b0;
        cap_cfg   = 32'h0;
        pwm_in    = 1'b0;
        rx_ack    = 1'b0;
        sb_ignore = 1'b0;
        repeat (3) @(negedge hclk);
        check("rst_word",    rx_word, 32'h0);
        check("rst_valid",   32'(rx_valid), 32'd0);
        check("rst_irq",     32'(rx_irq), 32'd0);
        check("rst_overrun", 32'(rx_overrun), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        check("rst_hi",      32'(hi_width), 32'd0);
        check("rst_lo",      32'(lo_width), 32'd0);
        hresetn = 1'b1;

        // Single word, 10 cycles/bit, sample phase 4
        cap_cfg = 32'h0004_0009;
        rearm();
        check("t1_arm_busy", 32'(busy), 32'd0);
        irq0 = irq_cnt;
        sb_q.push_back(32'hA5A5_0F01);
        drive_bits({32'h0, 32'hA5A5_0F01}, 32, 10, 4, 1'b1, -1);
        repeat (6) @(negedge hclk);
        check("t1_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t1_valid",    32'(rx_valid), 32'd1);
        check("t1_overrun",  32'(rx_overrun), 32'd0);
        check("t1_irqs",     32'(irq_cnt - irq0), 32'd1);
        check("t1_busy",     32'(busy), 32'd1);
        @(negedge hclk); rx_ack = 1'b1;
        @(negedge hclk); rx_ack = 1'b0;
        check("t1_ack_clr",  32'(rx_valid), 32'd0);

        // Back-to-back words without ack -> overrun
        rearm();
        irq0 = irq_cnt;
        sb_q.push_back(32'h0000_0001);
        sb_q.push_back(32'hFFFF_FFFF);
        drive_bits({32'hFFFF_FFFF, 32'h0000_0001}, 64, 10, 4, 1'b1, -1);
        repeat (6) @(negedge hclk);
        check("t2_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t2_word",     rx_word, 32'hFFFF_FFFF);
        check("t2_valid",    32'(rx_valid), 32'd1);
        check("t2_overrun",  32'(rx_overrun), 32'd1);
        check("t2_irqs",     32'(irq_cnt - irq0), 32'd2);
        pulse_rst();
        check("t2_rst_word",    rx_word, 32'h0);
        check("t2_rst_valid",   32'(rx_valid), 32'd0);
        check("t2_rst_overrun", 32'(rx_overrun), 32'd0);
        check("t2_rst_hi",      32'(hi_width), 32'd0);
        check("t2_rst_lo",      32'(lo_width), 32'd0);
        check("t2_rst_busy",    32'(busy), 32'd0);

        // Same pair, ack coincident with the second completion (sample cycle 2+63*10+4)
        rearm();
        irq0 = irq_cnt;
        sb_q.push_back(32'h0000_0001);
        sb_q.push_back(32'hFFFF_FFFF);
        drive_bits({32'hFFFF_FFFF, 32'h0000_0001}, 64, 10, 4, 1'b1, 636);
        repeat (6) @(negedge hclk);
        check("t3_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t3_valid",    32'(rx_valid), 32'd1);
        check("t3_overrun",  32'(rx_overrun), 32'd0);
        check("t3_irqs",     32'(irq_cnt - irq0), 32'd2);

        // Width meter: 30 high / 70 low square wave, then a saturating high run
        rearm();
        sb_ignore = 1'b1;
        for (int k = 0; k < 2; k++) begin
            pwm_in = 1'b1;
            repeat (30) @(negedge hclk);
            pwm_in = 1'b0;
            repeat (70) @(negedge hclk);
        end
        pwm_in = 1'b1;
        repeat (5) @(negedge hclk);
        check("t4_hi", 32'(hi_width), 32'd30);
        check("t4_lo", 32'(lo_width), 32'd70);
        repeat (70000) @(negedge hclk);
        pwm_in = 1'b0;
        repeat (5) @(negedge hclk);
        check("t4_hi_sat", 32'(hi_width), 32'h0000_FFFF);

        // cap_rst after 17 bits of a word
        rearm();
        sb_ignore = 1'b0;
        check("t5_pre_valid", 32'(rx_valid), 32'd1);
        irq0 = irq_cnt;
        drive_bits({32'h0, 32'h1234_5679}, 17, 10, 4, 1'b1, -1);
        pwm_in = 1'b0;
        repeat (4) @(negedge hclk);
        check("t5_pre_busy", 32'(busy), 32'd1);
        pulse_rst();
        check("t5_idle_busy", 32'(busy), 32'd0);
        check("t5_valid",     32'(rx_valid), 32'd0);
        check("t5_overrun",   32'(rx_overrun), 32'd0);
        check("t5_hi",        32'(hi_width), 32'd0);
        check("t5_lo",        32'(lo_width), 32'd0);
        @(negedge hclk);
        check("t5_arm_busy",  32'(busy), 32'd0);
        sb_q.push_back(32'h8000_0001);
        drive_bits({32'h0, 32'h8000_0001}, 32, 10, 4, 1'b1, -1);
        repeat (6) @(negedge hclk);
        check("t5_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t5_irqs",     32'(irq_cnt - irq0), 32'd1);
        check("t5_valid2",   32'(rx_valid), 32'd1);

        // cap_en dropped mid-word, then re-enabled for a fresh word
        rearm();
        irq0 = irq_cnt;
        drive_bits({32'h0, 32'hC0FF_EE11}, 10, 10, 4, 1'b1, -1);
        @(negedge hclk);
        cap_en = 1'b0;
        @(negedge hclk);
        check("t6_busy_off", 32'(busy), 32'd0);
        repeat (40) @(negedge hclk);
        check("t6_no_irq",   32'(irq_cnt - irq0), 32'd0);
        check("t6_word_hold", rx_word, 32'h8000_0001);
        check("t6_valid_hold", 32'(rx_valid), 32'd1);
        rearm();
        sb_q.push_back(32'hC0FF_EE11);
        drive_bits({32'h0, 32'hC0FF_EE11}, 32, 10, 4, 1'b1, -1);
        repeat (6) @(negedge hclk);
        check("t6_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t6_irqs",     32'(irq_cnt - irq0), 32'd1);

        // P=0: one bit per cycle, two continuous words
        cap_cfg = 32'h0000_0000;
        rearm();
        irq0 = irq_cnt;
        sb_q.push_back(32'hDEAD_BEEF);
        sb_q.push_back(32'h1357_9BDF);
        drive_bits({32'h1357_9BDF, 32'hDEAD_BEEF}, 64, 1, 0, 1'b0, -1);
        repeat (6) @(negedge hclk);
        check("t7_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t7_irqs",     32'(irq_cnt - irq0), 32'd2);

        // S beyond P: sampling clamps to phase 15 of a 16-cycle bit
        cap_cfg = 32'h0020_000F;
        rearm();
        irq0 = irq_cnt;
        sb_q.push_back(32'h5A5A_F00F);
        drive_bits({32'h0, 32'h5A5A_F00F}, 32, 16, 15, 1'b1, -1);
        repeat (6) @(negedge hclk);
        check("t8_sb_empty", 32'(sb_q.size()), 32'd0);
        check("t8_irqs",     32'(irq_cnt - irq0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
